// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage
//   Instruction fetch front end. Issues one word-address request at a time to
//   instruction memory, buffers returned words (with their addresses) in a
//   small FIFO, and presents the FIFO head to the datapath with a
//   valid/ready handshake. A redirect from the datapath flushes the buffer,
//   reloads the fetch PC, and discards any response still in flight.
//
// Parameters
//   RESET_PC  first fetch address after reset
//   DEPTH     instruction buffer entries (2..4)
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   imem_req, imem_addr    fetch request (accepted the cycle it is high)
//   imem_valid, imem_data  memory response strobe and instruction word
//   redirect, redirect_pc  branch/jump: new fetch address, highest priority
//   instr_valid/ready      head-of-buffer handshake with the datapath
//   instr, instr_pc        head instruction word and its address
//   stall_cnt              cycles with no instruction available
//
// Optional feature
//   FETCH_STALL_CNT_EN     when defined, stall_cnt is a saturating count of
//                          cycles with instr_valid=0; otherwise it is tied 0.
// ----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [7:0] RESET_PC = 8'h00,
    parameter int         DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [7:0]  imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_data,
    input  logic        redirect,
    input  logic [7:0]  redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [7:0]  instr_pc,
    output logic [15:0] stall_cnt
);

    typedef enum logic [1:0] {
        IDLE,   // nothing outstanding
        WAIT,   // request outstanding, response will be buffered
        DROP    // request outstanding, response will be discarded
    } state_t;

    localparam logic [2:0] OCC_MAX  = 3'(DEPTH);
    localparam logic [1:0] PTR_LAST = 2'(DEPTH - 1);

    state_t      state, state_nxt;
    logic [7:0]  fetch_pc;
    logic [7:0]  req_pc;
    logic [1:0]  head, tail;
    logic [2:0]  occ;
    logic [31:0] buf_data [4];
    logic [7:0]  buf_pc   [4];
    logic        issue, write, pop;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == PTR_LAST) ? 2'd0 : p + 2'd1;
    endfunction

    // Only one request can be outstanding and a new one is issued only while
    // a free slot exists, so the slot is effectively reserved at issue time:
    // pops can only make room, and a returning word can never overflow.
    // rst_n gates the request so it is low for the whole reset interval.
    assign issue = rst_n && (state == IDLE) && (occ < OCC_MAX) && !redirect;
    assign write = (state == WAIT) && imem_valid && !redirect;
    assign pop   = instr_valid && instr_ready && !redirect;

    assign imem_req    = issue;
    assign imem_addr   = fetch_pc;
    assign instr_valid = (occ != 3'd0);
    assign instr       = buf_data[head];
    assign instr_pc    = buf_pc[head];

    // NOTE: every variable assigned in always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (issue) state_nxt = WAIT;
            // A response arriving together with a redirect completes the
            // outstanding request (its data is discarded), so there is
            // nothing left to drop and the machine returns to IDLE.
            WAIT: begin
                if (imem_valid)    state_nxt = IDLE;
                else if (redirect) state_nxt = DROP;
            end
            DROP: if (imem_valid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    // NOTE: the buffer storage is reset because instr/instr_pc must read 0
    // out of reset; it is at most four small entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
            head     <= '0;
            tail     <= '0;
            occ      <= '0;
            for (int i = 0; i < 4; i++) begin
                buf_data[i] <= '0;
                buf_pc[i]   <= '0;
            end
        end else begin
            state <= state_nxt;
            if (redirect) begin
                fetch_pc <= redirect_pc;
                head     <= '0;
                tail     <= '0;
                occ      <= '0;
            end else begin
                if (issue) begin
                    req_pc   <= fetch_pc;
                    fetch_pc <= fetch_pc + 8'd1;
                end
                if (write) begin
                    buf_data[tail] <= imem_data;
                    buf_pc[tail]   <= req_pc;
                    tail           <= ptr_inc(tail);
                end
                if (pop) begin
                    head <= ptr_inc(head);
                end
                if (write && !pop) begin
                    occ <= occ + 3'd1;
                end else if (!write && pop) begin
                    occ <= occ - 3'd1;
                end
            end
        end
    end

`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (!instr_valid && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// ----------------------------------------------------------------------------
// tb_fetch_stage
//   Directed bench for fetch_stage. Two instances share clock, reset and
//   datapath controls: u_dut0 (RESET_PC=00) carries most scenarios, u_dut1
//   (RESET_PC=FE) shows the PC wrap. A behavioural memory answers each
//   accepted request after a programmable latency and keeps answering across
//   a reset, which produces the late, stale response the design must ignore.
// ----------------------------------------------------------------------------
module tb_fetch_stage;

`ifdef FETCH_STALL_CNT_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect;
    logic [7:0]  redirect_pc;
    logic        instr_ready;

    logic [1:0]  imem_req;
    logic [7:0]  imem_addr   [2];
    logic [1:0]  imem_valid;
    logic [31:0] imem_data   [2];
    logic [1:0]  instr_valid;
    logic [31:0] instr       [2];
    logic [7:0]  instr_pc    [2];
    logic [15:0] stall_cnt   [2];

    int checks = 0;
    int errors = 0;

    // memory model controls
    int          lat       = 1;
    bit          data_mode = 1'b0;
    bit          pend      [2];
    int          cnt       [2];
    logic [7:0]  paddr     [2];

    // observation logs
    logic [7:0]  req_q0 [$];
    logic [7:0]  hs_pc0 [$];
    logic [31:0] hs_in0 [$];
    logic [7:0]  hs_pc1 [$];
    int          nvalid_cyc = 0;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(8'h00), .DEPTH(2)) u_dut0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req[0]),
        .imem_addr   (imem_addr[0]),
        .imem_valid  (imem_valid[0]),
        .imem_data   (imem_data[0]),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid[0]),
        .instr_ready (instr_ready),
        .instr       (instr[0]),
        .instr_pc    (instr_pc[0]),
        .stall_cnt   (stall_cnt[0])
    );

    fetch_stage #(.RESET_PC(8'hFE), .DEPTH(2)) u_dut1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req[1]),
        .imem_addr   (imem_addr[1]),
        .imem_valid  (imem_valid[1]),
        .imem_data   (imem_data[1]),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid[1]),
        .instr_ready (instr_ready),
        .instr       (instr[1]),
        .instr_pc    (instr_pc[1]),
        .stall_cnt   (stall_cnt[1])
    );

    function automatic logic [31:0] resp(input logic [7:0] a);
        return data_mode ? {a ^ 8'h5A, 8'hC3, ~a, a} : {24'h0, a};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Memory: sample accepted requests just before each rising edge, drive
    // the response strobe on the falling edge so it is stable at the next one.
    initial begin
        imem_valid   = '0;
        imem_data[0] = '0;
        imem_data[1] = '0;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        forever begin
            @(posedge clk);
            for (int k = 0; k < 2; k++) begin
                if (rst_n && imem_req[k]) begin
                    pend[k]  = 1'b1;
                    cnt[k]   = lat;
                    paddr[k] = imem_addr[k];
                    if (k == 0) req_q0.push_back(imem_addr[k]);
                end
            end
            @(negedge clk);
            imem_valid = '0;
            for (int k = 0; k < 2; k++) begin
                if (pend[k]) begin
                    cnt[k]--;
                    if (cnt[k] == 0) begin
                        imem_valid[k] = 1'b1;
                        imem_data[k]  = resp(paddr[k]);
                        pend[k]       = 1'b0;
                    end
                end
            end
        end
    end

    // Completed handshakes and starvation cycles, as seen at each edge.
    always @(posedge clk) begin
        if (rst_n && !redirect && instr_ready) begin
            if (instr_valid[0]) begin
                hs_pc0.push_back(instr_pc[0]);
                hs_in0.push_back(instr[0]);
            end
            if (instr_valid[1]) hs_pc1.push_back(instr_pc[1]);
        end
        if (!rst_n) nvalid_cyc <= 0;
        else if (!instr_valid[0]) nvalid_cyc <= nvalid_cyc + 1;
    end

    task automatic clear_logs();
        req_q0.delete();
        hs_pc0.delete();
        hs_in0.delete();
        hs_pc1.delete();
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        clear_logs();
    endtask

    task automatic wait_req(input logic [7:0] addr, input string tag);
        bit found = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            @(negedge clk);
            if (req_q0.size() > 0 && req_q0[req_q0.size() - 1] == addr) found = 1'b1;
        end
        check(tag, 32'(found), 32'd1);
    endtask

    initial begin
        logic [7:0] exp_pc;
        rst_n       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 8'h00;
        instr_ready = 1'b1;

        // reset values
        repeat (2) @(negedge clk);
        check("rst_req0",   32'(imem_req[0]),    32'd0);
        check("rst_addr0",  32'(imem_addr[0]),   32'h00);
        check("rst_valid0", 32'(instr_valid[0]), 32'd0);
        check("rst_instr0", instr[0],            32'd0);
        check("rst_pc0",    32'(instr_pc[0]),    32'd0);
        check("rst_stall0", 32'(stall_cnt[0]),   32'd0);
        check("rst_req1",   32'(imem_req[1]),    32'd0);
        check("rst_addr1",  32'(imem_addr[1]),   32'hFE);
        check("rst_valid1", 32'(instr_valid[1]), 32'd0);

        // continuous flow, latency 1, data = address
        lat = 1;
        rst_n = 1'b1;
        clear_logs();
        repeat (12) @(negedge clk);
        check("flow_first_req", 32'(req_q0.size() > 0 ? req_q0[0] : 8'hXX), 32'h00);
        check("flow_n0", 32'(hs_pc0.size() >= 4), 32'd1);
        for (int i = 0; i < 4; i++) begin
            if (i < hs_pc0.size()) begin
                check($sformatf("flow_pc%0d", i),    32'(hs_pc0[i]), 32'(i));
                check($sformatf("flow_instr%0d", i), hs_in0[i],      32'(i));
            end
        end
        check("wrap_n1", 32'(hs_pc1.size() >= 4), 32'd1);
        exp_pc = 8'hFE;
        for (int i = 0; i < 4; i++) begin
            if (i < hs_pc1.size()) check($sformatf("wrap_pc%0d", i), 32'(hs_pc1[i]), 32'(exp_pc));
            exp_pc = exp_pc + 8'd1;
        end

        // back-pressure: buffer fills after two requests and holds its head
        instr_ready = 1'b0;
        reset_dut();
        repeat (10) @(negedge clk);
        check("bp_nreq", req_q0.size(), 32'd2);
        if (req_q0.size() == 2) begin
            check("bp_req0", 32'(req_q0[0]), 32'h00);
            check("bp_req1", 32'(req_q0[1]), 32'h01);
        end
        for (int i = 0; i < 4; i++) begin
            check("bp_req_low", 32'(imem_req[0]), 32'd0);
            check("bp_head", {instr_valid[0], 15'd0, instr_pc[0], instr[0][7:0]}, {1'b1, 31'd0});
            @(negedge clk);
        end
        instr_ready = 1'b1;
        repeat (8) @(negedge clk);
        check("bp_drain_n", 32'(hs_pc0.size() >= 3), 32'd1);
        for (int i = 0; i < 3; i++) begin
            if (i < hs_pc0.size()) check($sformatf("bp_drain_pc%0d", i), 32'(hs_pc0[i]), 32'(i));
        end

        // redirect while request 05 is outstanding
        lat = 3;
        data_mode = 1'b1;
        reset_dut();
        wait_req(8'h05, "redir_wait05");
        hs_pc0.delete();
        hs_in0.delete();
        req_q0.delete();
        redirect    = 1'b1;
        redirect_pc = 8'h40;
        check("redir_noreq", 32'(imem_req[0]), 32'd0);
        @(negedge clk);
        redirect = 1'b0;
        check("redir_valid_after", 32'(instr_valid[0]), 32'd0);
        repeat (14) @(negedge clk);
        check("redir_first_req", 32'(req_q0.size() > 0 ? req_q0[0] : 8'hXX), 32'h40);
        check("redir_n", 32'(hs_pc0.size() >= 2), 32'd1);
        if (hs_pc0.size() >= 2) begin
            check("redir_pc0",    32'(hs_pc0[0]), 32'h40);
            check("redir_instr0", hs_in0[0],      32'h1AC3BF40);
            check("redir_pc1",    32'(hs_pc0[1]), 32'h41);
            check("redir_instr1", hs_in0[1],      32'h1BC3BE41);
        end

        // reset pulse mid-request; stale response lands just after release
        data_mode = 1'b0;
        reset_dut();
        wait_req(8'h02, "rst_mid_wait02");
        @(negedge clk);
        rst_n = 1'b0;
        clear_logs();
        check("rst_mid_req", 32'(imem_req[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_mid_stale", 32'(instr_valid[0]), 32'd0);
        check("rst_mid_restart", 32'(req_q0.size() > 0 ? req_q0[0] : 8'hXX), 32'h00);
        repeat (10) @(negedge clk);
        check("rst_mid_n", 32'(hs_pc0.size() >= 2), 32'd1);
        for (int i = 0; i < 2; i++) begin
            if (i < hs_pc0.size()) begin
                check($sformatf("rst_mid_pc%0d", i),    32'(hs_pc0[i]), 32'(i));
                check($sformatf("rst_mid_instr%0d", i), hs_in0[i],      32'(i));
            end
        end

        // starvation counter, latency 3: one valid cycle in every four
        reset_dut();
        check("stall_rel", 32'(stall_cnt[0]), 32'd0);
        repeat (4) @(negedge clk);
        check("stall_first_valid", 32'(instr_valid[0]), 32'd1);
        check("stall_e3", 32'(stall_cnt[0]), STALL_EN ? 32'd4 : 32'd0);
        repeat (8) @(negedge clk);
        check("stall_e11", 32'(stall_cnt[0]), STALL_EN ? 32'd10 : 32'd0);
        check("stall_track", 32'(stall_cnt[0]), STALL_EN ? 32'(nvalid_cyc) : 32'd0);
        check("stall_dut1", 32'(stall_cnt[1]), STALL_EN ? 32'd10 : 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
